// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared widths, types and constants for the RV32I register file.
// Ports   : none (package)
// Config  : REGFILE_BYPASS_EN (consumed by regfile_rdport)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hard-wired to zero; every write/read path checks against this.
  localparam reg_addr_t REG_ZERO = '0;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_if.sv
// ============================================================================
// Module  : regfile_if
// Purpose : Bundles the register-file read/write bus between the ID/WB logic
//           (master) and the register file (slave).
// Signals : i_rs1_addr, i_rs2_addr  read indices        (master -> slave)
//           i_rd_addr, i_rd_wren,
//           i_rd_data               write port          (master -> slave)
//           o_rs1_data, o_rs2_data  read data           (slave  -> master)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] i_rs1_addr;
  logic [ADDR_W-1:0] i_rs2_addr;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              i_rd_wren;
  logic [XLEN-1:0]   i_rd_data;
  logic [XLEN-1:0]   o_rs1_data;
  logic [XLEN-1:0]   o_rs2_data;

  modport master (
    output i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_wren, i_rd_data,
    input  o_rs1_data, o_rs2_data
  );

  modport slave (
    input  i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_wren, i_rd_data,
    output o_rs1_data, o_rs2_data
  );

endinterface

`default_nettype wire

// File: rtl/regfile_rdport.sv
// ============================================================================
// Module  : regfile_rdport
// Purpose : One combinational read port: index decode, x0 mask, reset mask
//           and optional write-through bypass.
// Ports   : i_rst_n    async active-low reset (forces data to 0 while low)
//           i_rs_addr  read index
//           i_rd_addr, i_rd_wren, i_rd_data  write port (bypass source)
//           i_regs     flattened register view, entry 0 tied to zero
//           o_rs_data  read data
// Config  : REGFILE_BYPASS_EN - same-cycle forwarding of the write data
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::REG_ADDR_W
) (
  input  wire logic                           i_rst_n,
  input  wire logic [ADDR_W-1:0]              i_rs_addr,
  input  wire logic [ADDR_W-1:0]              i_rd_addr,
  input  wire logic                           i_rd_wren,
  input  wire logic [XLEN-1:0]                i_rd_data,
  input  wire logic [NUM_REGS-1:0][XLEN-1:0]  i_regs,
  output logic      [XLEN-1:0]                o_rs_data
);

  logic w_rs_is_zero;
  assign w_rs_is_zero = (i_rs_addr == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic w_bypass_hit;
  assign w_bypass_hit = i_rd_wren
                      && (i_rd_addr != ADDR_W'(REG_ZERO))
                      && (i_rd_addr == i_rs_addr);
`else
  // Write port only feeds the bypass; keep it visibly consumed.
  logic unused_wr_port;
  assign unused_wr_port = ^{i_rd_addr, i_rd_wren, i_rd_data};
`endif

  always_comb begin
    o_rs_data = '0;
    // Outputs read zero for the whole time reset is held, even if a
    // write (and hence a bypass) is presented on the bus.
    if (i_rst_n && !w_rs_is_zero) begin
`ifdef REGFILE_BYPASS_EN
      if (w_bypass_hit) begin
        o_rs_data = i_rd_data;
      end else begin
        o_rs_data = i_regs[i_rs_addr];
      end
`else
      o_rs_data = i_regs[i_rs_addr];
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module  : regfile
// Purpose : RV32I integer register file, 32 x XLEN, two combinational read
//           ports and one synchronous write port. x0 reads zero and has no
//           storage.
// Ports   : i_clk    core clock, rising edge
//           i_rst_n  asynchronous active-low reset, clears x1..x31
//           bus      regfile_if.slave (rs1/rs2 read, rd write)
// Config  : REGFILE_BYPASS_EN - write-through from the write port to read
//           ports on an index match (x0 never bypassed)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile
  import regfile_pkg::*;
#(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::REG_ADDR_W
) (
  input  wire logic  i_clk,
  input  wire logic  i_rst_n,
  regfile_if.slave   bus
);

  // Storage for x1..x(NUM_REGS-1) only.
  logic [XLEN-1:0] mem_q [1:NUM_REGS-1];
  logic [XLEN-1:0] mem_d [1:NUM_REGS-1];

  // Flattened read view with entry 0 tied off to zero.
  logic [NUM_REGS-1:0][XLEN-1:0] w_regs;

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (bus.i_rd_wren && (bus.i_rd_addr == ADDR_W'(i))) begin
        mem_d[i] = bus.i_rd_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_regs[i] = mem_q[i];
    end
  end

  regfile_rdport #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rdport_rs1 (
    .i_rst_n   (i_rst_n),
    .i_rs_addr (bus.i_rs1_addr),
    .i_rd_addr (bus.i_rd_addr),
    .i_rd_wren (bus.i_rd_wren),
    .i_rd_data (bus.i_rd_data),
    .i_regs    (w_regs),
    .o_rs_data (bus.o_rs1_data)
  );

  regfile_rdport #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rdport_rs2 (
    .i_rst_n   (i_rst_n),
    .i_rs_addr (bus.i_rs2_addr),
    .i_rd_addr (bus.i_rd_addr),
    .i_rd_wren (bus.i_rd_wren),
    .i_rd_data (bus.i_rd_data),
    .i_regs    (w_regs),
    .o_rs_data (bus.o_rs2_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module  : tb_regfile
// Purpose : Self-checking bench for regfile: directed vector table, hand
//           sequences for reset corner cases, and a random scoreboard run.
// Config  : REGFILE_BYPASS_EN changes the expected same-cycle read values.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic i_clk;
  logic i_rst_n;

  regfile_if #(.XLEN(32), .ADDR_W(5)) bus ();

  regfile #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors    = 0;
  int miscompares = 0;

  // Architectural state of x0..x31 as the ISA defines it.
  logic [31:0] model [32];

  typedef struct {
    bit          wren;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read value from the register-file rules.
  function automatic logic [31:0] exp_read(input int a, input bit we, input int rd,
                                           input logic [31:0] d);
    if (a == 0) return 32'h0;
    if (BYP && we && rd == a) return d;
    return model[a];
  endfunction

  task automatic drive(input bit we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.i_rd_wren  = we;
    bus.i_rd_addr  = rd;
    bus.i_rd_data  = d;
    bus.i_rs1_addr = rs1;
    bus.i_rs2_addr = rs2;
  endtask

  function automatic void model_write(input bit we, input logic [4:0] rd, input logic [31:0] d);
    if (we && rd != 5'd0) model[rd] = d;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Directed table: reads are sampled before the edge that commits the write.
    tbl[0] = '{1'b1, 5'd5, 32'h0000_0057, 5'd0, 5'd0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 32'h0000_0057, 32'h0000_0057};
    tbl[2] = '{1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 32'h0, 32'h0000_0057};
    tbl[4] = '{1'b1, 5'd7, 32'h1111_1111, 5'd7, 5'd5,
               BYP ? 32'h1111_1111 : 32'h0, 32'h0000_0057};
    tbl[5] = '{1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7,
               BYP ? 32'h2222_2222 : 32'h1111_1111,
               BYP ? 32'h2222_2222 : 32'h1111_1111};
    tbl[6] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 32'h2222_2222, 32'h0};
    tbl[7] = '{1'b0, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd9, 32'h0, 32'h0};
    tbl[8] = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd7, 32'h0, 32'h2222_2222};

    // ---------------- reset held: every address reads zero ----------------
    i_rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      @(negedge i_clk);
      drive(1'b1, 5'(a), 32'hA5A5_A5A5, 5'(a), 5'(31 - a));
      #2;
      check("reset_rs1", bus.o_rs1_data, 32'h0);
      check("reset_rs2", bus.o_rs2_data, 32'h0);
    end
    @(negedge i_clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    i_rst_n = 1'b1;

    // ---------------- directed table ----------------
    for (int k = 0; k < 9; k++) begin
      @(negedge i_clk);
      drive(tbl[k].wren, tbl[k].rd, tbl[k].data, tbl[k].rs1, tbl[k].rs2);
      #2;
      check($sformatf("tbl%0d_rs1", k), bus.o_rs1_data, tbl[k].e1);
      check($sformatf("tbl%0d_rs2", k), bus.o_rs2_data, tbl[k].e2);
      model_write(tbl[k].wren, tbl[k].rd, tbl[k].data);
    end
    // Post-edge view of the read-during-write case.
    @(negedge i_clk);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
    #2;
    check("rdw_after_edge", bus.o_rs1_data, 32'h2222_2222);
    check("wren0_x9", bus.o_rs2_data, 32'h0);

    // ---------------- reset priority over a concurrent write ----------------
    @(negedge i_clk);
    drive(1'b1, 5'd12, 32'h1234_5678, 5'd12, 5'd12);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd7);
    i_rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #2;
    check("rst_prio_x12", bus.o_rs1_data, 32'h0);
    check("rst_clr_x7", bus.o_rs2_data, 32'h0);

    // ---------------- fill x1..x31 with index, then async reset ----------------
    for (int a = 1; a < 32; a++) begin
      @(negedge i_clk);
      drive(1'b1, 5'(a), 32'(a), 5'd0, 5'd0);
      model_write(1'b1, 5'(a), 32'(a));
    end
    @(negedge i_clk);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    #2;
    check("fill_x31", bus.o_rs1_data, 32'd31);
    check("fill_x1", bus.o_rs2_data, 32'd1);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;   // between edges: no clock edge before the checks
    #1;
    check("async_rst_x31", bus.o_rs1_data, 32'h0);
    check("async_rst_x1", bus.o_rs2_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.i_rs1_addr = 5'(a);
      bus.i_rs2_addr = 5'(31 - a);
      #0.1;
      check("async_sweep_rs1", bus.o_rs1_data, 32'h0);
      check("async_sweep_rs2", bus.o_rs2_data, 32'h0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // ---------------- random scoreboard ----------------
    for (int n = 0; n < 1000; n++) begin
      bit          we;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] d;
      @(negedge i_clk);
      we  = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, 31));
      d   = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(we, rd, d, rs1, rs2);
      #2;
      check("rand_rs1", bus.o_rs1_data, exp_read(int'(rs1), we, int'(rd), d));
      check("rand_rs2", bus.o_rs2_data, exp_read(int'(rs2), we, int'(rd), d));
      model_write(we, rd, d);
    end

    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
